dm_dma: RTL
===========

Name: dm_dma

Overview:
- Block-copy / block-fill engine; the initiator that drives the data memory (DM) read/write port.
- Moves a contiguous byte range inside DM, or fills a range with a constant, without CPU involvement.
- Sits between the control unit and DM. The control unit stalls the CPU and muxes the DM port to this block while busy=1.

Parameters:
ADDR_W, 8, DM address width (DM depth 2^ADDR_W)
DATA_W, 8, DM data width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle request pulse; sampled only in IDLE
mode  input  1  0 = copy, 1 = fill; latched on accepted start
src_addr  input  ADDR_W  copy source base address; latched on start
dst_addr  input  ADDR_W  destination base address; latched on start
len  input  ADDR_W  byte count; 0 = no transfer; latched on start
fill_data  input  DATA_W  fill value; latched on start
busy  output  1  high from the cycle after accepted start until DONE inclusive
done  output  1  one-cycle completion pulse
DM_r_en  output  1  DM read enable
DM_w_en  output  1  DM write enable
addr  output  ADDR_W  DM address
DM_w_data  output  DATA_W  DM write data
i_DM_data  input  DATA_W  DM read data; combinational, valid in the same cycle as DM_r_en

Behaviour:
- Reset, asynchronous: state=IDLE. All internal registers are 0: cnt, data_buf, and the latched src/dst/len/mode/fill.
- Reset value of every output is 0.
- Outputs are Moore-decoded from state and registers. No output depends combinationally on start.
- The same reset behaviour applies mid-transfer: the transfer aborts immediately and DM writes stop. Bytes already written stay written.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - All DM strobes are 0.
  - start=1 latches all inputs and clears cnt.
  - If len=0, go to DONE.
  - Otherwise go to READ (mode=0) or WRITE (mode=1).
- READ (copy only):
  - DM_r_en=1, addr=src+cnt (mod 2^ADDR_W).
  - data_buf<=i_DM_data at the clock edge.
  - Next state is WRITE.
- WRITE:
  - DM_w_en=1, addr=dst+cnt (mod 2^ADDR_W).
  - DM_w_data=data_buf in copy mode, fill_data in fill mode.
  - If cnt==len-1, go to DONE.
  - Otherwise cnt<=cnt+1 and go to READ (copy) or stay in WRITE (fill).
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- DM_r_en and DM_w_en are never high in the same cycle.
- addr=0 whenever both strobes are low.
- Latency from the start edge to the done cycle:
  - copy: 2*len+1 cycles
  - fill: len+1 cycles
  - len=0: 1 cycle
- Address arithmetic wraps modulo 2^ADDR_W; no error is flagged.
- Byte count is at most 255; len is not extended.
- Overlap: the copy is strictly forward and byte-serial, and no hazard detection is done.
  - Consequence: dst=src+1 replicates byte src across the range.
  - This behaviour is specified and must be preserved.
- start while not in IDLE is ignored. Inputs changing while busy have no effect.
- done and a new start in the same cycle: start is ignored, because state is DONE, not IDLE.
- DM timing: writes commit at the clock edge ending the WRITE cycle, and reads are combinational. A byte written at cnt=k is visible to the READ at cnt=k+1.

Test Plan:
- Copy: preload DM[0x10..0x13]=A1,B2,C3,D4, start with mode=0 src=0x10 dst=0x80 len=4.
  - Required: done exactly 9 cycles after the start edge.
  - DM[0x80..0x83]=A1,B2,C3,D4; source unchanged.
  - Strobes alternate r,w,r,w… and are never both high.
- Fill: mode=1 dst=0x20 len=3 fill_data=0x5A.
  - Required: three consecutive DM_w_en cycles at 0x20,0x21,0x22 with data 0x5A, done 4 cycles after start, no DM_r_en ever.
- Wrap and len=0:
  - copy src=0xFE dst=0x40 len=4: reads at FE,FF,00,01.
  - len=0: done 1 cycle after start, zero strobes, busy high for one cycle only.
- Overlap: DM[0x30]=0x77, copy src=0x30 dst=0x31 len=3.
  - Required: DM[0x31..0x33]=77,77,77.
- Start while busy: pulse start with different args during a copy.
  - Required: ignored; the original transfer completes with unchanged timing.
  - A start on the done cycle is also ignored.
- Reset mid-op: assert rst during the WRITE of byte 2 of a len=6 copy.
  - Required: all outputs 0 immediately, state IDLE, only bytes 0–1 written.
  - A new start after rst release works normally.

Source files
------------

// File: rtl/dm_dma.sv
`default_nettype none
// ============================================================================
//  Module   : dm_dma
//  Purpose  : Block-copy / block-fill engine driving the data-memory port.
//             Copies a contiguous byte range inside DM (byte-serial, strictly
//             forward, read then write per byte) or fills a range with a
//             constant. Addresses wrap modulo 2^ADDR_W.
//  Ports    : clk, rst            - clock, async active-high reset
//             start               - request pulse, honoured only when idle
//             mode                - 0 = copy, 1 = fill
//             src_addr, dst_addr  - source / destination base addresses
//             len                 - byte count (0 = no transfer)
//             fill_data           - constant written in fill mode
//             busy, done          - status / one-cycle completion pulse
//             DM_r_en, DM_w_en    - DM strobes (never both high)
//             addr, DM_w_data     - DM address / write data
//             i_DM_data           - DM read data, combinational with DM_r_en
//  Revision : 1.0 - initial release
// ============================================================================
module dm_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              DM_r_en,
  output logic              DM_w_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] DM_w_data,
  input  logic [DATA_W-1:0] i_DM_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   buf_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W-1:0]   len_q;
  logic                mode_q;
  logic [DATA_W-1:0]   fill_q;
  logic                busy_q;
  logic                done_q;
  logic                r_en_q;
  logic                w_en_q;
  logic [ADDR_W-1:0]   addr_q;

  logic [ADDR_W-1:0]   cnt_d;
  logic                last_d;

  assign cnt_d  = cnt_q + c_ONE;
  assign last_d = (cnt_q == (len_q - c_ONE));

  // Strobes and address are registered one step ahead: every branch that
  // enters a state also loads the strobes/address that state presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_en_q  <= 1'b0;
      w_en_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      r_en_q <= 1'b0;
      w_en_q <= 1'b0;
      addr_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            len_q  <= len;
            mode_q <= mode;
            fill_q <= fill_data;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (mode) begin
              state_q <= ST_WRITE;
              w_en_q  <= 1'b1;
              addr_q  <= dst_addr;
            end else begin
              state_q <= ST_READ;
              r_en_q  <= 1'b1;
              addr_q  <= src_addr;
            end
          end
        end
        ST_READ: begin
          buf_q   <= i_DM_data;
          state_q <= ST_WRITE;
          w_en_q  <= 1'b1;
          addr_q  <= dst_q + cnt_q;
        end
        ST_WRITE: begin
          if (last_d) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
            if (mode_q) begin
              state_q <= ST_WRITE;
              w_en_q  <= 1'b1;
              addr_q  <= dst_q + cnt_d;
            end else begin
              state_q <= ST_READ;
              r_en_q  <= 1'b1;
              addr_q  <= src_q + cnt_d;
            end
          end
        end
        default: begin  // ST_DONE
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign DM_r_en   = r_en_q;
  assign DM_w_en   = w_en_q;
  assign addr      = addr_q;
  // Write data is only driven during a write so the bus idles at zero.
  assign DM_w_data = w_en_q ? (mode_q ? fill_q : buf_q) : '0;

endmodule
`default_nettype wire
